// File: rtl/mm_seq_ctrl_pkg.sv
// mm_pkg: shared types and sizing helpers for the matrix-multiply phase
// sequencer (mm_seq_ctrl) and its stream/BRAM/systolic interface.
//
// Contents
//   mm_state_t   sequencer state encoding, also exported on state_o
//   *_DEF        default engine configuration (M, N, CRED, TIMEOUT)
//   ld_beats()   number of input beats per job (A then B)
//   dr_beats()   number of result beats per job
//   cnt_w()      bits needed to index 0..n-1 (never less than 1)
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    ERR     = 3'd4
  } mm_state_t;

  localparam int unsigned M_DEF       = 15;
  localparam int unsigned N_DEF       = 3;
  localparam int unsigned CRED_DEF    = 4;
  localparam int unsigned TIMEOUT_DEF = 4096;

  function automatic int unsigned ld_beats(input int unsigned m);
    return 2 * m * m;
  endfunction

  function automatic int unsigned dr_beats(input int unsigned m);
    return m * m;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned LD_BEATS = ld_beats(M_DEF);
  localparam int unsigned DR_BEATS = dr_beats(M_DEF);
  localparam int unsigned LD_AW    = cnt_w(LD_BEATS);
  localparam int unsigned DR_AW    = cnt_w(DR_BEATS);

endpackage

// File: rtl/mm_seq_ctrl_if.sv
// mm_seq_if: handshake bundle between the phase sequencer and the
// datapath (input DMA stream, load BRAM writer, systolic array, drain
// reader and output skid buffer).
//
// Signals
//   s_tvalid/s_tlast   input stream beat qualifiers (datapath -> ctrl)
//   s_tready           input stream ready, LOAD only (ctrl -> datapath)
//   ld_en/ld_addr      load write strobe and linear index (<M*M is A)
//   sa_rst/sa_start    systolic reset (low only in COMPUTE) and start pulse
//   sa_done            last result word written (datapath -> ctrl)
//   dr_en/dr_addr      drain read issue and address
//   dr_last            marks the final drain read, carried to tlast
//   m_hs               output tvalid&tready observed (datapath -> ctrl)
//
// Modports: master = sequencer side, slave = datapath side.
interface mm_seq_if
  import mm_pkg::*;
#(
  parameter int unsigned M = M_DEF
) ();

  localparam int unsigned IF_LD_AW = cnt_w(ld_beats(M));
  localparam int unsigned IF_DR_AW = cnt_w(dr_beats(M));

  logic                s_tvalid;
  logic                s_tlast;
  logic                s_tready;
  logic                ld_en;
  logic [IF_LD_AW-1:0] ld_addr;
  logic                sa_rst;
  logic                sa_start;
  logic                sa_done;
  logic                dr_en;
  logic [IF_DR_AW-1:0] dr_addr;
  logic                dr_last;
  logic                m_hs;

  modport master (
    input  s_tvalid, s_tlast, sa_done, m_hs,
    output s_tready, ld_en, ld_addr, sa_rst, sa_start, dr_en, dr_addr, dr_last
  );

  modport slave (
    output s_tvalid, s_tlast, sa_done, m_hs,
    input  s_tready, ld_en, ld_addr, sa_rst, sa_start, dr_en, dr_addr, dr_last
  );

endinterface

// File: rtl/mm_seq_ctrl_credit_cnt.sv
// mm_credit_cnt: drain credit counter. Starts at CRED (free slots in the
// output skid buffer), decrements on each drain read issue, increments on
// each observed output handshake; simultaneous inc/dec leaves it unchanged.
//
// Ports
//   i_clk    clock
//   i_rst_n  synchronous active-low reset (reloads CRED)
//   i_clr    synchronous reload to CRED
//   i_inc    one slot freed
//   i_dec    one slot consumed
//   o_cnt    current credit
module mm_credit_cnt #(
  parameter int unsigned CRED = 4,
  parameter int unsigned W    = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] FULL = W'(CRED);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= FULL;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + W'(1);
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // The sequencer gates both strobes; these catch a broken caller.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clr) begin
      assert (!(i_dec && !i_inc && (r_cnt == '0)));
      assert (!(i_inc && !i_dec && (r_cnt == FULL)));
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: phase sequencer for the MxM matrix-multiply engine.
// IDLE -> LOAD (2*M*M beats, A then B) -> COMPUTE -> DRAIN (M*M reads) -> IDLE,
// with ERR on protocol/watchdog faults. Drain reads are credit-limited so
// the output skid buffer (CRED deep) can never overflow.
//
// Ports
//   mm_clk, mm_rst_n   clock, synchronous active-low reset
//   bus                mm_seq_if.master: stream, load, systolic, drain handshakes
//   err_clr            clears sticky flags; leaves ERR for IDLE
//   cfg_n              systolic width N (informational)
//   state_o            current state (mm_state_t encoding)
//   done_p             1-cycle pulse on the last accepted result beat
//   err_early_last     sticky: s_tlast before the final load beat
//   err_no_last        sticky: final load beat without s_tlast
//   err_timeout        sticky: COMPUTE watchdog expired
//   perf_cmp_cyc       COMPUTE cycles of the current job
//   perf_dr_stall      DRAIN cycles stalled on zero credit
//
// Build option: define MM_PERF_CNT_EN to implement the two performance
// counters; otherwise they read 0 and no counter flops exist.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned M       = M_DEF,
  parameter int unsigned N       = N_DEF,
  parameter int unsigned CRED    = CRED_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        mm_clk,
  input  logic        mm_rst_n,
  mm_seq_if.master    bus,
  input  logic        err_clr,
  output logic [7:0]  cfg_n,
  output logic [2:0]  state_o,
  output logic        done_p,
  output logic        err_early_last,
  output logic        err_no_last,
  output logic        err_timeout,
  output logic [31:0] perf_cmp_cyc,
  output logic [31:0] perf_dr_stall
);

  localparam int unsigned LD_N  = ld_beats(M);
  localparam int unsigned DR_N  = dr_beats(M);
  localparam int unsigned LA_W  = cnt_w(LD_N);
  localparam int unsigned DA_W  = cnt_w(DR_N);
  localparam int unsigned CNT_W = cnt_w(DR_N + 1);
  localparam int unsigned WD_W  = cnt_w(TIMEOUT);
  localparam int unsigned CR_W  = cnt_w(CRED + 1);

  localparam logic [LA_W-1:0]  LD_LAST   = LA_W'(LD_N - 1);
  localparam logic [CNT_W-1:0] ISS_END   = CNT_W'(DR_N);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(DR_N - 1);
  localparam logic [DA_W-1:0]  DR_LAST_A = DA_W'(DR_N - 1);
  localparam logic [CR_W-1:0]  CRED_FULL = CR_W'(CRED);
  localparam bit               WD_EN     = (TIMEOUT != 0);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  mm_state_t        r_state, w_next;
  logic [LA_W-1:0]  r_ld_cnt;
  logic [WD_W-1:0]  r_wd;
  logic [CNT_W-1:0] r_issued, r_accepted;
  logic             r_sa_start;
  logic             r_err_early, r_err_nolast, r_err_to;

  logic [CR_W-1:0]  w_credit;
  logic             w_ld_en, w_dr_en, w_hs_ok, w_done, w_wd_exp;
  logic             w_set_early, w_set_nolast, w_set_to;

  // Credit is held at CRED outside DRAIN so every drain starts full.
  mm_credit_cnt #(
    .CRED (CRED),
    .W    (CR_W)
  ) u_credit (
    .i_clk   (mm_clk),
    .i_rst_n (mm_rst_n),
    .i_clr   (r_state != DRAIN),
    .i_inc   (w_hs_ok),
    .i_dec   (w_dr_en),
    .o_cnt   (w_credit)
  );

  always_ff @(posedge mm_clk) begin
    if (!mm_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_set_early  = 1'b0;
    w_set_nolast = 1'b0;
    w_set_to     = 1'b0;
    w_ld_en      = (r_state == LOAD) && bus.s_tvalid;
    w_dr_en      = (r_state == DRAIN) && (w_credit != '0) && (r_issued < ISS_END);
    // A handshake with no word outstanding cannot be real; drop it.
    w_hs_ok      = (r_state == DRAIN) && bus.m_hs && (w_credit != CRED_FULL);
    w_done       = w_hs_ok && (r_accepted == ACC_LAST);
    w_wd_exp     = WD_EN && (r_wd == WD_LAST);

    bus.s_tready = (r_state == LOAD);
    bus.ld_en    = w_ld_en;
    bus.ld_addr  = r_ld_cnt;
    bus.sa_rst   = (r_state != COMPUTE);
    bus.sa_start = r_sa_start;
    bus.dr_en    = w_dr_en;
    bus.dr_addr  = r_issued[DA_W-1:0];
    bus.dr_last  = w_dr_en && (r_issued[DA_W-1:0] == DR_LAST_A);
    done_p       = w_done;

    case (r_state)
      IDLE: w_next = LOAD;
      LOAD: begin
        if (w_ld_en) begin
          if (r_ld_cnt == LD_LAST) begin
            // A missing tlast is flagged but the job still runs.
            w_next       = COMPUTE;
            w_set_nolast = !bus.s_tlast;
          end else if (bus.s_tlast) begin
            w_next      = ERR;
            w_set_early = 1'b1;
          end
        end
      end
      COMPUTE: begin
        // sa_done takes priority over a watchdog expiring in the same cycle.
        if (bus.sa_done) begin
          w_next = DRAIN;
        end else if (w_wd_exp) begin
          w_next   = ERR;
          w_set_to = 1'b1;
        end
      end
      DRAIN: begin
        if (w_done) begin
          w_next = IDLE;
        end
      end
      ERR: begin
        if (err_clr) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Each phase counter runs only in its own state and is zero elsewhere,
  // so leaving a phase by any path (done, error, clear) restarts it.
  always_ff @(posedge mm_clk) begin
    if (!mm_rst_n) begin
      r_ld_cnt   <= '0;
      r_wd       <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_sa_start <= 1'b0;
    end else begin
      r_ld_cnt   <= (r_state == LOAD) ? (r_ld_cnt + LA_W'(w_ld_en)) : '0;
      r_wd       <= (r_state == COMPUTE) ? (r_wd + WD_W'(1)) : '0;
      r_issued   <= (r_state == DRAIN) ? (r_issued + CNT_W'(w_dr_en)) : '0;
      r_accepted <= (r_state == DRAIN) ? (r_accepted + CNT_W'(w_hs_ok)) : '0;
      r_sa_start <= (r_state == LOAD) && (w_next == COMPUTE);
    end
  end

  // A fault in the same cycle as err_clr stays visible.
  always_ff @(posedge mm_clk) begin
    if (!mm_rst_n) begin
      r_err_early  <= 1'b0;
      r_err_nolast <= 1'b0;
      r_err_to     <= 1'b0;
    end else begin
      r_err_early  <= w_set_early  | (r_err_early  & ~err_clr);
      r_err_nolast <= w_set_nolast | (r_err_nolast & ~err_clr);
      r_err_to     <= w_set_to     | (r_err_to     & ~err_clr);
    end
  end

  always_ff @(posedge mm_clk) begin
    if (mm_rst_n && (r_state == DRAIN) && bus.m_hs) begin
      assert (w_credit != CRED_FULL);
    end
  end

`ifdef MM_PERF_CNT_EN
  logic [31:0] r_perf_cmp, r_perf_stall;

  // IDLE always moves to LOAD, so clearing in IDLE clears on LOAD entry.
  always_ff @(posedge mm_clk) begin
    if (!mm_rst_n || (r_state == IDLE)) begin
      r_perf_cmp   <= '0;
      r_perf_stall <= '0;
    end else begin
      if ((r_state == COMPUTE) && (r_perf_cmp != '1)) begin
        r_perf_cmp <= r_perf_cmp + 32'd1;
      end
      if ((r_state == DRAIN) && (w_credit == '0) && (r_issued < ISS_END) &&
          (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_cmp_cyc  = r_perf_cmp;
  assign perf_dr_stall = r_perf_stall;
`else
  assign perf_cmp_cyc  = '0;
  assign perf_dr_stall = '0;
`endif

  assign cfg_n          = 8'(N);
  assign state_o        = r_state;
  assign err_early_last = r_err_early;
  assign err_no_last    = r_err_nolast;
  assign err_timeout    = r_err_to;

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl with M=3, CRED=2, TIMEOUT=16.
// A small datapath stand-in returns one output handshake per issued drain
// read (one cycle later at the earliest) whenever the sink is ready.
module tb_mm_seq_ctrl;
  import mm_pkg::*;

  logic        mm_clk;
  logic        mm_rst_n;
  logic        err_clr;
  logic [7:0]  cfg_n;
  logic [2:0]  state_o;
  logic        done_p;
  logic        err_early_last, err_no_last, err_timeout;
  logic [31:0] perf_cmp_cyc, perf_dr_stall;

  int n_checks = 0;
  int n_errors = 0;
  int n_dren, n_done, n_last, last_addr, pend;
  logic sink_rdy;

  mm_seq_if #(.M(3)) bus ();

  mm_seq_ctrl #(
    .M(3), .N(3), .CRED(2), .TIMEOUT(16)
  ) dut (
    .mm_clk         (mm_clk),
    .mm_rst_n       (mm_rst_n),
    .bus            (bus),
    .err_clr        (err_clr),
    .cfg_n          (cfg_n),
    .state_o        (state_o),
    .done_p         (done_p),
    .err_early_last (err_early_last),
    .err_no_last    (err_no_last),
    .err_timeout    (err_timeout),
    .perf_cmp_cyc   (perf_cmp_cyc),
    .perf_dr_stall  (perf_dr_stall)
  );

  initial mm_clk = 1'b0;
  always #5 mm_clk = ~mm_clk;

  initial begin
    #100000;
    $display("FAIL tb_time_limit: observed=running required=finished");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Closes the current cycle: records drain activity, advances to just
  // after the edge and presents the next output handshake.
  task automatic tick();
    if (bus.dr_en === 1'b1) begin
      check("dr_addr", 32'(bus.dr_addr), 32'(n_dren));
      n_dren++;
      pend++;
    end
    if (bus.dr_last === 1'b1) begin
      n_last++;
      last_addr = int'(bus.dr_addr);
    end
    if (bus.m_hs === 1'b1) pend--;
    if (done_p === 1'b1) n_done++;
    @(posedge mm_clk);
    #1;
    bus.m_hs = (pend > 0) && sink_rdy;
    #1;
  endtask

  task automatic set_sink(input logic v);
    sink_rdy = v;
    bus.m_hs = (pend > 0) && sink_rdy;
    #1;
  endtask

  task automatic reset_counts();
    n_dren = 0; n_done = 0; n_last = 0; last_addr = -1;
  endtask

  task automatic load_beats(input int n, input int tlast_idx);
    for (int k = 0; k < n; k++) begin
      bus.s_tvalid = 1'b1;
      bus.s_tlast  = (k == tlast_idx);
      #1;
      check("ld_en", 32'(bus.ld_en), 32'd1);
      check("ld_addr", 32'(bus.ld_addr), 32'(k));
      tick();
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    #1;
  endtask

  task automatic drain_until_done(input int budget);
    int c = 0;
    while ((n_done == 0) && (c < budget)) begin
      tick();
      c++;
    end
    check("drain_done_within_budget", 32'(n_done != 0), 32'd1);
  endtask

  task automatic check_state(input string tag, input mm_state_t s);
    check(tag, 32'(state_o), 32'(s));
  endtask

  initial begin
    mm_rst_n = 1'b0; err_clr = 1'b0; sink_rdy = 1'b1; pend = 0;
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.sa_done = 1'b0; bus.m_hs = 1'b0;
    reset_counts();
    tick(); tick();

    // Reset state
    check_state("rst_state", IDLE);
    check("rst_sa_rst", 32'(bus.sa_rst), 32'd1);
    check("rst_s_tready", 32'(bus.s_tready), 32'd0);
    check("rst_ld_en", 32'(bus.ld_en), 32'd0);
    check("rst_ld_addr", 32'(bus.ld_addr), 32'd0);
    check("rst_sa_start", 32'(bus.sa_start), 32'd0);
    check("rst_dr_en", 32'(bus.dr_en), 32'd0);
    check("rst_dr_last", 32'(bus.dr_last), 32'd0);
    check("rst_done_p", 32'(done_p), 32'd0);
    check("rst_flags", 32'({err_early_last, err_no_last, err_timeout}), 32'd0);
    check("rst_perf_cmp", perf_cmp_cyc, 32'd0);
    check("rst_perf_stall", perf_dr_stall, 32'd0);
    check("cfg_n", 32'(cfg_n), 32'd3);

    mm_rst_n = 1'b1;
    tick();
    check_state("idle_to_load", LOAD);
    check("load_s_tready", 32'(bus.s_tready), 32'd1);

    // Job 1: normal job, sa_done in COMPUTE cycle 10
    reset_counts();
    load_beats(18, 17);
    check_state("j1_compute", COMPUTE);
    check("j1_sa_start", 32'(bus.sa_start), 32'd1);
    check("j1_sa_rst", 32'(bus.sa_rst), 32'd0);
    check("j1_s_tready", 32'(bus.s_tready), 32'd0);
    check("j1_no_flags", 32'({err_early_last, err_no_last}), 32'd0);
    tick();
    check("j1_sa_start_pulse", 32'(bus.sa_start), 32'd0);
    repeat (8) tick();
    bus.sa_done = 1'b1;
    tick();
    bus.sa_done = 1'b0;
    #1;
    check_state("j1_drain", DRAIN);
    check("j1_drain_sa_rst", 32'(bus.sa_rst), 32'd1);
    check("j1_first_dr_en", 32'(bus.dr_en), 32'd1);
    drain_until_done(40);
    check_state("j1_idle", IDLE);
    check("j1_dr_en_count", 32'(n_dren), 32'd9);
    check("j1_done_count", 32'(n_done), 32'd1);
    check("j1_dr_last_count", 32'(n_last), 32'd1);
    check("j1_dr_last_addr", 32'(last_addr), 32'd8);
`ifdef MM_PERF_CNT_EN
    check("j1_perf_cmp", perf_cmp_cyc, 32'd10);
    check("j1_perf_stall", perf_dr_stall, 32'd0);
`else
    check("j1_perf_cmp_off", perf_cmp_cyc, 32'd0);
    check("j1_perf_stall_off", perf_dr_stall, 32'd0);
`endif
    tick();
    check_state("j1_next_load", LOAD);

    // Job 2: tlast on beat index 5
    load_beats(6, 5);
    check_state("j2_err", ERR);
    check("j2_err_early", 32'(err_early_last), 32'd1);
    check("j2_s_tready", 32'(bus.s_tready), 32'd0);
    check("j2_sa_rst", 32'(bus.sa_rst), 32'd1);
    bus.s_tvalid = 1'b1;
    #1;
    check("j2_ld_en_blocked", 32'(bus.ld_en), 32'd0);
    bus.s_tvalid = 1'b0;
    tick();
    check_state("j2_err_hold", ERR);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check_state("j2_clr_idle", IDLE);
    check("j2_flag_cleared", 32'(err_early_last), 32'd0);
    tick();
    check_state("j2_load", LOAD);

    // Job 3: no tlast on the final beat
    reset_counts();
    load_beats(18, -1);
    check_state("j3_compute", COMPUTE);
    check("j3_err_no_last", 32'(err_no_last), 32'd1);
    check("j3_err_early", 32'(err_early_last), 32'd0);
    bus.sa_done = 1'b1;
    tick();
    bus.sa_done = 1'b0;
    #1;
    check_state("j3_drain", DRAIN);
    drain_until_done(40);
    check("j3_dr_en_count", 32'(n_dren), 32'd9);
    check_state("j3_idle", IDLE);
    check("j3_sticky", 32'(err_no_last), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check_state("j3_load", LOAD);
    check("j3_flag_cleared", 32'(err_no_last), 32'd0);

    // Job 4: watchdog expires at COMPUTE cycle 16
    load_beats(18, 17);
    check_state("j4_compute", COMPUTE);
    repeat (15) tick();
    check_state("j4_cycle16", COMPUTE);
    check("j4_no_timeout_yet", 32'(err_timeout), 32'd0);
    tick();
    check_state("j4_err", ERR);
    check("j4_err_timeout", 32'(err_timeout), 32'd1);
    check("j4_dr_en", 32'(bus.dr_en), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check_state("j4_idle", IDLE);
    check("j4_flag_cleared", 32'(err_timeout), 32'd0);
    tick();
    check_state("j4_load", LOAD);

    // Job 5: sa_done at COMPUTE cycle 15, output held off for 6 cycles
    reset_counts();
    load_beats(18, 17);
    repeat (14) tick();
    check_state("j5_cycle15", COMPUTE);
    set_sink(1'b0);
    bus.sa_done = 1'b1;
    tick();
    bus.sa_done = 1'b0;
    #1;
    check_state("j5_drain", DRAIN);
    check("j5_no_timeout", 32'(err_timeout), 32'd0);
    repeat (6) tick();
    check("j5_dr_en_before_release", 32'(n_dren), 32'd2);
    check("j5_stalled", 32'(bus.dr_en), 32'd0);
`ifdef MM_PERF_CNT_EN
    check("j5_stall_so_far", perf_dr_stall, 32'd4);
`else
    check("j5_stall_off", perf_dr_stall, 32'd0);
`endif
    set_sink(1'b1);
    drain_until_done(40);
    check_state("j5_idle", IDLE);
    check("j5_dr_en_count", 32'(n_dren), 32'd9);
    check("j5_done_count", 32'(n_done), 32'd1);
    check("j5_dr_last_addr", 32'(last_addr), 32'd8);
`ifdef MM_PERF_CNT_EN
    check("j5_perf_cmp", perf_cmp_cyc, 32'd15);
    check("j5_perf_stall", perf_dr_stall, 32'd5);
`else
    check("j5_perf_cmp_off", perf_cmp_cyc, 32'd0);
`endif
    tick();
    check_state("j5_load", LOAD);

    // Job 6: reset while stalled in DRAIN
    reset_counts();
    load_beats(18, 17);
    set_sink(1'b0);
    bus.sa_done = 1'b1;
    tick();
    bus.sa_done = 1'b0;
    #1;
    check_state("j6_drain", DRAIN);
    repeat (4) tick();
    check("j6_credit_exhausted", 32'(bus.dr_en), 32'd0);
`ifdef MM_PERF_CNT_EN
    check("j6_stall_held", perf_dr_stall, 32'd2);
`else
    check("j6_stall_off", perf_dr_stall, 32'd0);
`endif
    mm_rst_n = 1'b0;
    tick();
    pend = 0;
    bus.m_hs = 1'b0;
    sink_rdy = 1'b1;
    #1;
    check_state("j6_rst_idle", IDLE);
    check("j6_rst_sa_rst", 32'(bus.sa_rst), 32'd1);
    check("j6_rst_dr_en", 32'(bus.dr_en), 32'd0);
    check("j6_rst_done_p", 32'(done_p), 32'd0);
    check("j6_rst_credit", 32'(dut.u_credit.o_cnt), 32'd2);
    check("j6_no_done", 32'(n_done), 32'd0);
    check("j6_rst_perf_stall", perf_dr_stall, 32'd0);
    mm_rst_n = 1'b1;
    tick();
    check_state("j6_load", LOAD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
